alu_issue_arbiter: RTL
======================

Name: alu_issue_arbiter

Overview:
Shares the single Rapids ALU between two requesters, such as the integer issue slot and the address/compare slot. Each requester has its own valid/ready handshake. The block round-robin arbitrates between them and registers the winning operation onto the ALU control and operand lines. After a fixed latency it captures Y1/Y2/compare_res and returns them on a response channel tagged with the requester ID. MULT and DIV are not implemented in the ALU, so they are rejected with an error response and never reach it.

Parameters:
LAT, 1, cycles from driving ALU inputs to sampling ALU outputs (1..7); allows a pipelined ALU later
TAGW, 4, width of the per-request tag echoed back on the response

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  synchronous active-low reset
req_valid  input  2  bit i = requester i presents an op
req_ready  output  2  bit i = op from requester i accepted this cycle
req_op  input  6  {op1[2:0], op0[2:0]} ALU base op per requester
req_form  input  2  form bit per requester
req_vec  input  4  {vec1, vec0} precision per requester
req_lsel  input  8  {lsel1, lsel0} logic_select per requester
req_opnd  input  256  {A1,B1,C1,D1,A0,B0,C0,D0}, 32 bits each
req_tag  input  2*TAGW  per-requester tag
alu_op  output  3  to ALU op
alu_form  output  1  to ALU form
alu_vec  output  2  to ALU vec
alu_lsel  output  4  to ALU logic_select
alu_A, alu_B, alu_C, alu_D  output  32 each  ALU operands
alu_Y1, alu_Y2  input  32 each  ALU results
alu_cmp  input  8  ALU compare_res
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that issued the op
rsp_tag  output  TAGW  echoed tag
rsp_Y1, rsp_Y2  output  32 each  captured results
rsp_cmp  output  8  captured compare_res
rsp_err  output  1  1 = op rejected (MULT 3'b001 / DIV 3'b101)
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (resetn low at a clk edge, from any state):
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - All alu_* outputs and rsp_* data outputs = 0.
  - rsp_valid=0; req_ready=0; wait counter=0.
  - An in-flight op is discarded with no response.
- IDLE, arbitration:
  - req_ready is combinational and is asserted only in IDLE and only for the granted requester.
  - Grant goes to the single requester if only one is valid.
  - If both are valid, grant goes to the one that is not last_grant.
  - On grant: update last_grant and latch id, tag, op, form, vec, lsel and operands.
- IDLE, legal op:
  - Drive alu_* from the latched values starting the next cycle.
  - Go to EXEC with counter=LAT.
- IDLE, illegal op (MULT or DIV):
  - alu_* outputs are not updated.
  - Go directly to RESP with rsp_err=1, Y1=Y2=0, cmp=0.
- EXEC:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, register alu_Y1/Y2/cmp into rsp_* with rsp_err=0, then go to RESP.
  - Issue-to-response latency is LAT+1 cycles after the req handshake; rsp_valid rises on cycle LAT+1.
  - alu_* outputs hold stable for the whole of EXEC.
- RESP:
  - rsp_valid=1; all rsp_* outputs hold stable while rsp_ready=0.
  - When rsp_valid and rsp_ready are both high, go to IDLE.
  - No new grant is given in the same cycle; the next req_ready can assert no earlier than the following cycle.
- alu_* retain their last-issued values in IDLE and RESP; they are not cleared.
- Only one op is in flight. Peak throughput is one op per LAT+2 cycles.
- A requester that drops req_valid before req_ready is never granted. Payload is sampled only at the handshake.
- Simultaneous valids with a held grant: after requester 0 is served, requester 1 wins next even if requester 0 re-requests.

Test Plan:
- Reset then single ADD from req0: A=5, C=7, B=1, D=2, vec=FULL, form=0, tag=3 -> req_ready[0] pulses once; rsp_valid two cycles later (LAT=1); rsp_Y1=12, rsp_Y2=3, rsp_id=0, rsp_tag=3, rsp_err=0.
- Both requesters valid continuously with 4 ops each -> grants alternate 0,1,0,1,...; each response carries the correct id and tag; no op is lost or duplicated.
- req1 issues DIV (op=3'b101) -> rsp_valid the cycle after the handshake; rsp_err=1, rsp_Y1=rsp_Y2=0; alu_op unchanged from the previous op.
- rsp_ready held low for 5 cycles in RESP -> rsp_* stable, req_ready stays 0, busy=1; after rsp_ready=1, IDLE next cycle.
- resetn low during EXEC -> next cycle state=IDLE, rsp_valid=0, alu_* = 0; no response emitted for the aborted op.
- LAT=3 build, SUB A=10, C=4 -> rsp_valid exactly 4 cycles after the handshake; rsp_Y1=6; alu_* stable across all of EXEC.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Shares one ALU between two requesters. Each requester has its own
// valid/ready handshake, and the two are served in round-robin order.
// Only one operation is in flight at a time. After LAT cycles the ALU
// results are captured and returned on a response channel tagged with
// the requester id. MULT and DIV are never sent to the ALU; they are
// answered straight away with an error response.

module alu_issue_arbiter #(
  parameter int unsigned LAT  = 1,
  parameter int unsigned TAGW = 4
) (
  input  logic              clk,
  input  logic              resetn,

  // Requester side: bit/slice i belongs to requester i
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [5:0]        req_op,
  input  logic [1:0]        req_form,
  input  logic [3:0]        req_vec,
  input  logic [7:0]        req_lsel,
  input  logic [255:0]      req_opnd,
  input  logic [2*TAGW-1:0] req_tag,

  // ALU control and operand lines
  output logic [2:0]        alu_op,
  output logic              alu_form,
  output logic [1:0]        alu_vec,
  output logic [3:0]        alu_lsel,
  output logic [31:0]       alu_A,
  output logic [31:0]       alu_B,
  output logic [31:0]       alu_C,
  output logic [31:0]       alu_D,
  input  logic [31:0]       alu_Y1,
  input  logic [31:0]       alu_Y2,
  input  logic [7:0]        alu_cmp,

  // Response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [31:0]       rsp_Y1,
  output logic [31:0]       rsp_Y2,
  output logic [7:0]        rsp_cmp,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] LatCnt = 3'(LAT);
  localparam logic [2:0] OpMult = 3'b001;
  localparam logic [2:0] OpDiv  = 3'b101;

  state_e            state_q;
  logic              lastGrant_q;
  logic [2:0]        waitCnt_q;

  logic              grantAny_d;
  logic              grantId_d;
  logic [2:0]        selOp_d;
  logic              selForm_d;
  logic [1:0]        selVec_d;
  logic [3:0]        selLsel_d;
  logic [127:0]      selOpnd_d;
  logic [TAGW-1:0]   selTag_d;
  logic              selIllegal_d;

  // Round-robin grant: a lone requester always wins; on a tie the
  // requester that did not win last time goes first.
  always_comb begin
    grantAny_d = 1'b0;
    grantId_d  = 1'b0;
    req_ready  = 2'b00;
    if (resetn && (state_q == IDLE) && (req_valid != 2'b00)) begin
      grantAny_d = 1'b1;
      if (req_valid == 2'b11) begin
        grantId_d = ~lastGrant_q;
      end else begin
        grantId_d = req_valid[1];
      end
      req_ready = grantId_d ? 2'b10 : 2'b01;
    end
  end

  // Steer the granted requester's payload onto a single set of lines.
  always_comb begin
    selOp_d   = req_op[2:0];
    selForm_d = req_form[0];
    selVec_d  = req_vec[1:0];
    selLsel_d = req_lsel[3:0];
    selOpnd_d = req_opnd[127:0];
    selTag_d  = req_tag[TAGW-1:0];
    if (grantId_d) begin
      selOp_d   = req_op[5:3];
      selForm_d = req_form[1];
      selVec_d  = req_vec[3:2];
      selLsel_d = req_lsel[7:4];
      selOpnd_d = req_opnd[255:128];
      selTag_d  = req_tag[2*TAGW-1:TAGW];
    end
    selIllegal_d = (selOp_d == OpMult) || (selOp_d == OpDiv);
  end

  // Issue/execute/respond sequencer; every output it drives is registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      waitCnt_q   <= 3'd0;
      alu_op      <= 3'd0;
      alu_form    <= 1'b0;
      alu_vec     <= 2'd0;
      alu_lsel    <= 4'd0;
      alu_A       <= 32'd0;
      alu_B       <= 32'd0;
      alu_C       <= 32'd0;
      alu_D       <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_tag     <= '0;
      rsp_Y1      <= 32'd0;
      rsp_Y2      <= 32'd0;
      rsp_cmp     <= 8'd0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantAny_d) begin
            lastGrant_q <= grantId_d;
            rsp_id      <= grantId_d;
            rsp_tag     <= selTag_d;
            busy        <= 1'b1;
            if (selIllegal_d) begin
              rsp_Y1    <= 32'd0;
              rsp_Y2    <= 32'd0;
              rsp_cmp   <= 8'd0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state_q   <= RESP;
            end else begin
              alu_op    <= selOp_d;
              alu_form  <= selForm_d;
              alu_vec   <= selVec_d;
              alu_lsel  <= selLsel_d;
              alu_A     <= selOpnd_d[127:96];
              alu_B     <= selOpnd_d[95:64];
              alu_C     <= selOpnd_d[63:32];
              alu_D     <= selOpnd_d[31:0];
              waitCnt_q <= LatCnt;
              state_q   <= EXEC;
            end
          end
        end

        EXEC: begin
          waitCnt_q <= waitCnt_q - 3'd1;
          if (waitCnt_q <= 3'd1) begin
            waitCnt_q <= 3'd0;
            rsp_Y1    <= alu_Y1;
            rsp_Y2    <= alu_Y2;
            rsp_cmp   <= alu_cmp;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule
